// File: rtl/bit_deser.sv
// Serial-to-parallel word assembler for the 1-bit mux output. It has a one-word
// holding register with a valid/ready handshake and a sticky overrun flag.
module bit_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_in,
  input  logic                     bit_vld,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_vld,
  input  logic                     word_rdy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic [0:0]     S_EMPTY = 1'b0;
  localparam logic [0:0]     S_FULL  = 1'b1;

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic [0:0]       r_state;
  logic             r_ovr;

  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_complete;
  logic             w_handshake;
  logic             w_drop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_shift_nxt = r_shift;
    if (MSB_FIRST) w_shift_nxt = {r_shift[WIDTH-2:0], bit_in};
    else           w_shift_nxt = {bit_in, r_shift[WIDTH-1:1]};
  end

  assign w_complete  = bit_vld && (r_cnt == LAST);
  assign w_handshake = (r_state == S_FULL) && word_rdy;
  assign w_drop      = w_complete && (r_state == S_FULL) && !w_handshake;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (bit_vld) begin
      r_shift <= w_shift_nxt;
      r_cnt   <= w_complete ? '0 : r_cnt + CW'(1);
    end
  end

  // A completed word is taken when the register is empty or is being drained
  // on this same edge; otherwise the new word is dropped and word_out is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_word  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_complete) begin
            r_word  <= w_shift_nxt;
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_handshake && w_complete) r_word  <= w_shift_nxt;
          else if (w_handshake)          r_state <= S_EMPTY;
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // Set wins over clear when both happen on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovr <= 1'b0;
    else if (w_drop)  r_ovr <= 1'b1;
    else if (ovr_clr) r_ovr <= 1'b0;
  end

  assign word_out = r_word;
  assign word_vld = (r_state == S_FULL);
  assign bit_cnt  = r_cnt;
  assign overrun  = r_ovr;

endmodule

// File: tb/tb_bit_deser.sv
// Bench for bit_deser. Two instances (MSB-first and LSB-first) share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_bit_deser;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0, bit_vld = 1'b0, word_rdy = 1'b0, ovr_clr = 1'b0;

  logic [W-1:0] m_out, l_out;
  logic         m_vld, l_vld, m_ovr, l_ovr;
  logic [2:0]   m_cnt, l_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
    .word_out(m_out), .word_vld(m_vld), .word_rdy(word_rdy),
    .bit_cnt(m_cnt), .overrun(m_ovr), .ovr_clr(ovr_clr)
  );

  bit_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
    .word_out(l_out), .word_vld(l_vld), .word_rdy(word_rdy),
    .bit_cnt(l_cnt), .overrun(l_ovr), .ovr_clr(ovr_clr)
  );

  // Reference model: the accepted bits are kept in a queue. A word is formed
  // arithmetically from the bits in arrival order, using both bit orders.
  bit       q[$];
  bit       e_full;
  bit [7:0] e_word_m, e_word_l;
  bit       e_ovr;
  bit       hs, done, was_full;
  bit [7:0] wm, wl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      e_full   = 1'b0;
      e_word_m = '0;
      e_word_l = '0;
      e_ovr    = 1'b0;
    end else begin
      was_full = e_full;
      hs       = e_full && word_rdy;
      done     = 1'b0;
      if (bit_vld) begin
        q.push_back(bit_in);
        if (q.size() == W) begin
          wm = '0;
          wl = '0;
          for (int i = 0; i < W; i++) begin
            wm = wm | (8'(q[i]) << (W - 1 - i));
            wl = wl | (8'(q[i]) << i);
          end
          q.delete();
          done = 1'b1;
        end
      end
      if (done && was_full && !hs) e_ovr = 1'b1;
      else if (ovr_clr)            e_ovr = 1'b0;
      if (done && (!was_full || hs)) begin
        e_full   = 1'b1;
        e_word_m = wm;
        e_word_l = wl;
      end else if (hs) begin
        e_full = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("msb_word", 32'(m_out), 32'(e_word_m));
    check("msb_vld",  32'(m_vld), 32'(e_full));
    check("msb_cnt",  32'(m_cnt), 32'(q.size()));
    check("msb_ovr",  32'(m_ovr), 32'(e_ovr));
    check("lsb_word", 32'(l_out), 32'(e_word_l));
    check("lsb_vld",  32'(l_vld), 32'(e_full));
    check("lsb_cnt",  32'(l_cnt), 32'(q.size()));
    check("lsb_ovr",  32'(l_ovr), 32'(e_ovr));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_word"}, 32'(m_out), 0);
    check({tag, "_vld"},  32'(m_vld), 0);
    check({tag, "_cnt"},  32'(m_cnt), 0);
    check({tag, "_ovr"},  32'(m_ovr), 0);
    check({tag, "_lword"}, 32'(l_out), 0);
    check({tag, "_lcnt"},  32'(l_cnt), 0);
  endtask

  task automatic cycle(input logic bv, input logic b, input logic rdy, input logic clr);
    bit_vld  = bv;
    bit_in   = b;
    word_rdy = rdy;
    ovr_clr  = clr;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input logic rdy);
    for (int i = 0; i < W; i++) begin
      for (int g = 1; g < gap; g++) cycle(1'b0, 1'b0, rdy, 1'b0);
      cycle(1'b1, w[W-1-i], rdy, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w0f;
    w0f = 8'h0F;

    #1 check_zero("rst_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Async reset mid-word clears all outputs without a clock edge.
    send_word(8'hB2, 1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_vld", 32'(m_vld), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Basic word in both bit orders, consumer ready.
    send_word(8'hB2, 1, 1'b1);
    check("t2_word", 32'(m_out), 32'h B2);
    check("t2_vld",  32'(m_vld), 1);
    check("t3_word", 32'(l_out), 32'h4D);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_vld_drop", 32'(m_vld), 0);
    check("t2_hold", 32'(m_out), 32'hB2);

    // Gapped strobe: one accepted bit every third cycle.
    send_word(8'hB2, 3, 1'b1);
    check("t4_word", 32'(m_out), 32'hB2);
    check("t4_cnt",  32'(m_cnt), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: the second word is dropped, then a clear pulse.
    send_word(8'hB2, 1, 1'b0);
    check("t5_ovr0", 32'(m_ovr), 0);
    send_word(8'h0F, 1, 1'b0);
    check("t5_word", 32'(m_out), 32'hB2);
    check("t5_ovr",  32'(m_ovr), 1);
    check("t5_lword", 32'(l_out), 32'h4D);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_clr", 32'(m_ovr), 0);
    check("t5_vld", 32'(m_vld), 1);

    // Same-edge handshake and completion: no bubble, no overrun.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_drain", 32'(m_vld), 0);
    send_word(8'hB2, 1, 1'b0);
    for (int i = 0; i < W - 1; i++) begin
      cycle(1'b1, w0f[W-1-i], 1'b0, 1'b0);
      check("t6_vld_held", 32'(m_vld), 1);
    end
    cycle(1'b1, w0f[0], 1'b1, 1'b0);
    check("t6_word", 32'(m_out), 32'h0F);
    check("t6_vld",  32'(m_vld), 1);
    check("t6_ovr",  32'(m_ovr), 0);
    check("t6_lword", 32'(l_out), 32'hF0);

    // Randomized traffic with occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_zero("rst_rand");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
